// File: rtl/image_ctrl_pkg.sv
// Shared types and default constants for the image frame scheduler.
// Holds the FSM state encoding and the parameter defaults used by the top.
package image_ctrl_pkg;

   localparam int TIME_WIDTH         = 64;
   localparam int DEF_QUEUE_DEPTH    = 8;
   localparam int DEF_FRAME_ID_WIDTH = 8;
   localparam int DEF_ACK_TIMEOUT    = 1024;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TIME = 2'd1,
      ISSUE     = 2'd2
   } sched_state_e;

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous show-ahead command FIFO with a registered occupancy count.
// Any depth is supported; pointers wrap explicitly rather than relying on powers of two.
module sched_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 72
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: storage has no reset; the count and pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/image_frame_scheduler.sv
// Time-triggered frame scheduler: queues {start time, frame} commands and issues
// each as a load request once the free-running counter reaches its start time.
module image_frame_scheduler
   import image_ctrl_pkg::*;
#(
   parameter int QUEUE_DEPTH    = DEF_QUEUE_DEPTH,
   parameter int FRAME_ID_WIDTH = DEF_FRAME_ID_WIDTH,
   parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
   input  logic                             s_axi_aclk,
   input  logic                             s_axi_aresetn,
   input  logic                             flush,
   input  logic                             cmd_valid,
   input  logic [TIME_WIDTH-1:0]            cmd_time,
   input  logic [FRAME_ID_WIDTH-1:0]        cmd_frame,
   output logic                             cmd_ready,
   input  logic                             auto_start,
   input  logic [TIME_WIDTH-1:0]            counter,
   output logic                             load_req,
   output logic [FRAME_ID_WIDTH-1:0]        load_frame,
   input  logic                             load_ack,
   output logic                             busy,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
   output logic                             late_pulse,
   output logic                             timeout_pulse,
   output logic                             done_pulse
);

   localparam int DW = TIME_WIDTH + FRAME_ID_WIDTH;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   sched_state_e              state;
   logic [TIME_WIDTH-1:0]     head_time;
   logic [FRAME_ID_WIDTH-1:0] head_frame;
   logic [TW-1:0]             timer;
   logic                      first_wait;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [DW-1:0]             fifo_rd_data;
   logic                      push;
   logic                      pop;

   assign cmd_ready = !fifo_full && !flush;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && !fifo_empty && auto_start && !flush;
   assign busy      = (state != IDLE);

   sched_cmd_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (DW)
   ) u_fifo (
      .clk     (s_axi_aclk),
      .rst_n   (s_axi_aresetn),
      .flush   (flush),
      .push    (push),
      .pop     (pop),
      .wr_data ({cmd_time, cmd_frame}),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (queue_count)
   );

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state         <= IDLE;
         head_time     <= '0;
         head_frame    <= '0;
         timer         <= '0;
         first_wait    <= 1'b0;
         load_req      <= 1'b0;
         load_frame    <= '0;
         late_pulse    <= 1'b0;
         timeout_pulse <= 1'b0;
         done_pulse    <= 1'b0;
      end else begin
         late_pulse    <= 1'b0;
         timeout_pulse <= 1'b0;
         done_pulse    <= 1'b0;
         if (flush) begin
            state      <= IDLE;
            load_req   <= 1'b0;
            first_wait <= 1'b0;
            timer      <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (pop) begin
                     {head_time, head_frame} <= fifo_rd_data;
                     first_wait              <= 1'b1;
                     state                   <= WAIT_TIME;
                  end
               end
               WAIT_TIME: begin
                  // Lateness is judged only on entry; a start time equal to now is on time.
                  first_wait <= 1'b0;
                  if (first_wait && (counter > head_time)) late_pulse <= 1'b1;
                  if (counter >= head_time) begin
                     state      <= ISSUE;
                     load_req   <= 1'b1;
                     load_frame <= head_frame;
                     timer      <= '0;
                  end
               end
               ISSUE: begin
                  if (load_ack) begin
                     load_req   <= 1'b0;
                     done_pulse <= 1'b1;
                     state      <= IDLE;
                  end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                     load_req      <= 1'b0;
                     timeout_pulse <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_image_frame_scheduler.sv
// Self-checking bench for image_frame_scheduler: a table of directed per-cycle
// vectors followed by hand-written full-queue, timeout, flush and reset sequences.
module tb_image_frame_scheduler;

   localparam int QD = 8;
   localparam int FW = 8;
   localparam int AT = 16;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          cmd_valid;
   logic [63:0]   cmd_time;
   logic [FW-1:0] cmd_frame;
   logic          cmd_ready;
   logic          auto_start;
   logic [63:0]   counter;
   logic          load_req;
   logic [FW-1:0] load_frame;
   logic          load_ack;
   logic          busy;
   logic [3:0]    queue_count;
   logic          late_pulse;
   logic          timeout_pulse;
   logic          done_pulse;

   int n_checks = 0;
   int n_errors = 0;

   image_frame_scheduler #(
      .QUEUE_DEPTH    (QD),
      .FRAME_ID_WIDTH (FW),
      .ACK_TIMEOUT    (AT)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .flush         (flush),
      .cmd_valid     (cmd_valid),
      .cmd_time      (cmd_time),
      .cmd_frame     (cmd_frame),
      .cmd_ready     (cmd_ready),
      .auto_start    (auto_start),
      .counter       (counter),
      .load_req      (load_req),
      .load_frame    (load_frame),
      .load_ack      (load_ack),
      .busy          (busy),
      .queue_count   (queue_count),
      .late_pulse    (late_pulse),
      .timeout_pulse (timeout_pulse),
      .done_pulse    (done_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          valid;
      logic [63:0]   ctime;
      logic [FW-1:0] frame;
      logic          auto;
      logic [63:0]   cnt;
      logic          ack;
      logic          e_req;
      logic [FW-1:0] e_frame;
      logic          e_busy;
      logic [3:0]    e_count;
      logic          e_late;
      logic          e_timeout;
      logic          e_done;
      logic          e_ready;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!load_req && n < 20) begin
         tick();
         n++;
      end
      check(name, 64'(load_req), 64'd1);
   endtask

   initial begin
      // valid time frame auto counter ack | req frame busy count late timeout done ready
      vecs[0]  = '{1, 50,  3, 1, 100, 1,  0, 0, 0, 1, 0, 0, 0, 1};
      vecs[1]  = '{0, 0,   0, 1, 100, 1,  0, 0, 1, 0, 0, 0, 0, 1};
      vecs[2]  = '{0, 0,   0, 1, 100, 1,  1, 3, 1, 0, 1, 0, 0, 1};
      vecs[3]  = '{0, 0,   0, 1, 100, 1,  0, 3, 0, 0, 0, 0, 1, 1};
      vecs[4]  = '{0, 0,   0, 1, 100, 0,  0, 3, 0, 0, 0, 0, 0, 1};
      vecs[5]  = '{1, 200, 7, 1, 150, 0,  0, 3, 0, 1, 0, 0, 0, 1};
      vecs[6]  = '{0, 0,   0, 1, 160, 0,  0, 3, 1, 0, 0, 0, 0, 1};
      vecs[7]  = '{0, 0,   0, 1, 170, 0,  0, 3, 1, 0, 0, 0, 0, 1};
      vecs[8]  = '{0, 0,   0, 0, 199, 0,  0, 3, 1, 0, 0, 0, 0, 1};
      vecs[9]  = '{0, 0,   0, 0, 200, 0,  1, 7, 1, 0, 0, 0, 0, 1};
      vecs[10] = '{0, 0,   0, 0, 201, 0,  1, 7, 1, 0, 0, 0, 0, 1};
      vecs[11] = '{0, 0,   0, 0, 202, 1,  0, 7, 0, 0, 0, 0, 1, 1};
      vecs[12] = '{1, 300, 9, 1, 290, 0,  0, 7, 0, 1, 0, 0, 0, 1};
      vecs[13] = '{0, 0,   0, 1, 295, 0,  0, 7, 1, 0, 0, 0, 0, 1};
      vecs[14] = '{0, 0,   0, 1, 300, 0,  1, 9, 1, 0, 0, 0, 0, 1};
      vecs[15] = '{0, 0,   0, 1, 301, 1,  0, 9, 0, 0, 0, 0, 1, 1};
      vecs[16] = '{0, 0,   0, 0, 302, 0,  0, 9, 0, 0, 0, 0, 0, 1};

      rst_n      = 1'b0;
      flush      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_time   = '0;
      cmd_frame  = '0;
      auto_start = 1'b0;
      counter    = '0;
      load_ack   = 1'b0;
      #12;
      check("rst_load_req", 64'(load_req), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_count", 64'(queue_count), 0);
      check("rst_ready", 64'(cmd_ready), 1);
      check("rst_pulses", 64'({late_pulse, timeout_pulse, done_pulse}), 0);
      rst_n = 1'b1;

      // Late issue, on-time issue with auto_start dropped in WAIT_TIME, equality not late.
      for (int i = 0; i < 17; i++) begin
         cmd_valid  = vecs[i].valid;
         cmd_time   = vecs[i].ctime;
         cmd_frame  = vecs[i].frame;
         auto_start = vecs[i].auto;
         counter    = vecs[i].cnt;
         load_ack   = vecs[i].ack;
         tick();
         check($sformatf("v%0d_req", i), 64'(load_req), 64'(vecs[i].e_req));
         check($sformatf("v%0d_frame", i), 64'(load_frame), 64'(vecs[i].e_frame));
         check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
         check($sformatf("v%0d_count", i), 64'(queue_count), 64'(vecs[i].e_count));
         check($sformatf("v%0d_late", i), 64'(late_pulse), 64'(vecs[i].e_late));
         check($sformatf("v%0d_timeout", i), 64'(timeout_pulse), 64'(vecs[i].e_timeout));
         check($sformatf("v%0d_done", i), 64'(done_pulse), 64'(vecs[i].e_done));
         check($sformatf("v%0d_ready", i), 64'(cmd_ready), 64'(vecs[i].e_ready));
      end

      // Fill the queue with auto_start low; the ninth push must be refused.
      auto_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cmd_valid = 1'b1;
         cmd_time  = 64'd0;
         cmd_frame = FW'(10 + i);
         #1;
         check($sformatf("fill%0d_ready", i), 64'(cmd_ready), (i < 8) ? 64'd1 : 64'd0);
         tick();
      end
      cmd_valid = 1'b0;
      check("full_count", 64'(queue_count), 8);
      check("full_busy", 64'(busy), 0);

      // Timeout on the first command, then the next command is issued.
      counter    = 64'd1000;
      auto_start = 1'b1;
      load_ack   = 1'b0;
      wait_req("to_req_rise");
      check("to_frame", 64'(load_frame), 10);
      begin
         int n = 0;
         while (load_req && n < 100) begin
            check("to_no_pulse", 64'({timeout_pulse, done_pulse}), 0);
            n++;
            tick();
         end
         check("to_req_cycles", 64'(n), 64'(AT));
      end
      check("to_pulse", 64'(timeout_pulse), 1);
      check("to_no_done", 64'(done_pulse), 0);
      for (int f = 11; f <= 14; f++) begin
         wait_req($sformatf("seq%0d_req", f));
         check($sformatf("seq%0d_frame", f), 64'(load_frame), 64'(f));
         if (f < 14) begin
            load_ack = 1'b1;
            tick();
            load_ack = 1'b0;
            check($sformatf("seq%0d_done", f), 64'(done_pulse), 1);
         end
      end
      check("pre_flush_count", 64'(queue_count), 3);

      // Flush during ISSUE overrides a same-cycle acknowledge.
      flush    = 1'b1;
      load_ack = 1'b1;
      #1;
      check("flush_ready", 64'(cmd_ready), 0);
      tick();
      check("flush_count", 64'(queue_count), 0);
      check("flush_req", 64'(load_req), 0);
      check("flush_busy", 64'(busy), 0);
      check("flush_done", 64'(done_pulse), 0);
      flush    = 1'b0;
      load_ack = 1'b0;
      tick();
      check("post_flush_busy", 64'(busy), 0);

      // Asynchronous reset in WAIT_TIME with one entry still queued.
      counter    = 64'd0;
      auto_start = 1'b1;
      cmd_valid  = 1'b1;
      cmd_time   = 64'd1000;
      cmd_frame  = FW'(20);
      tick();
      cmd_frame  = FW'(21);
      tick();
      cmd_valid  = 1'b0;
      check("wait_busy", 64'(busy), 1);
      check("wait_count", 64'(queue_count), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 0);
      check("arst_count", 64'(queue_count), 0);
      check("arst_req", 64'(load_req), 0);
      check("arst_frame", 64'(load_frame), 0);
      check("arst_pulses", 64'({late_pulse, timeout_pulse, done_pulse}), 0);
      #2;
      rst_n = 1'b1;
      auto_start = 1'b0;
      tick();
      check("post_rst_busy", 64'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
